// File: rtl/traffic_conflict_monitor.sv
// Intersection safety monitor: classifies observed lamp drives, debounces level
// violations, checks yellow timing on the straight heads and latches the first trip.
module traffic_conflict_monitor #(
    parameter int DEBOUNCE   = 3,
    parameter int MIN_YELLOW = 3,
    parameter int ARM_TIME   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       ns_str_green,
    input  logic       ns_str_yellow,
    input  logic       ns_str_red,
    input  logic       ns_left_green,
    input  logic       ns_left_yellow,
    input  logic       ns_left_red,
    input  logic       ns_ped_walk,
    input  logic       ew_str_green,
    input  logic       ew_str_yellow,
    input  logic       ew_str_red,
    input  logic       ew_left_green,
    input  logic       ew_left_yellow,
    input  logic       ew_left_red,
    input  logic       ew_ped_walk,
    input  logic       fault_clear,
    output logic       system_fault,
    output logic [2:0] fault_code,
    output logic       armed,
    output logic [7:0] fault_count,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {ST_ARM = 2'd0, ST_RUN = 2'd1, ST_TRIPPED = 2'd2} state_t;
    typedef enum logic [1:0] {CL_X = 2'd0, CL_G = 2'd1, CL_Y = 2'd2, CL_R = 2'd3} head_cls_t;

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int AW = (ARM_TIME > 1) ? $clog2(ARM_TIME) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIME - 1);
    localparam logic [3:0]    MIN_Y    = 4'(MIN_YELLOW);

    state_t        state;
    head_cls_t     cls_q   [2];
    head_cls_t     cls_now [2];
    logic [3:0]    ycnt_q  [2];
    logic [DW-1:0] db_cnt  [3];
    logic [AW-1:0] arm_cnt;
    logic [2:0]    cond;
    logic [2:0]    trip_code;
    logic [1:0]    skip;
    logic [1:0]    short_y;
    logic          ns_gy;
    logic          ew_gy;

    function automatic head_cls_t classify(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return CL_G;
            3'b010:  return CL_Y;
            3'b001:  return CL_R;
            default: return CL_X;
        endcase
    endfunction

    function automatic logic two_lit(input logic g, input logic y, input logic r);
        return (g & y) | (g & r) | (y & r);
    endfunction

    assign ns_gy   = ns_str_green | ns_str_yellow | ns_left_green | ns_left_yellow;
    assign ew_gy   = ew_str_green | ew_str_yellow | ew_left_green | ew_left_yellow;
    assign cond[0] = ns_gy & ew_gy;
    assign cond[1] = (ns_ped_walk & ew_gy) | (ew_ped_walk & ns_gy);
    assign cond[2] = two_lit(ns_str_green, ns_str_yellow, ns_str_red)
                   | two_lit(ns_left_green, ns_left_yellow, ns_left_red)
                   | two_lit(ew_str_green, ew_str_yellow, ew_str_red)
                   | two_lit(ew_left_green, ew_left_yellow, ew_left_red);

    assign cls_now[0] = classify(ns_str_green, ns_str_yellow, ns_str_red);
    assign cls_now[1] = classify(ew_str_green, ew_str_yellow, ew_str_red);

    // Priority encode: lowest code wins when several violations land on one edge.
    always_comb begin
        skip      = '0;
        short_y   = '0;
        trip_code = 3'd0;
        for (int h = 0; h < 2; h++) begin
            skip[h]    = (cls_q[h] == CL_G) && (cls_now[h] == CL_R);
            short_y[h] = (cls_q[h] == CL_Y) && (cls_now[h] == CL_R) && (ycnt_q[h] < MIN_Y);
        end
        if (cond[0] && db_cnt[0] == DB_LAST)      trip_code = 3'd1;
        else if (cond[1] && db_cnt[1] == DB_LAST) trip_code = 3'd2;
        else if (cond[2] && db_cnt[2] == DB_LAST) trip_code = 3'd3;
        else if (|skip)                           trip_code = 3'd4;
        else if (|short_y)                        trip_code = 3'd5;
    end

    // Head classes track in every state so that re-arming never sees a stale history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < 2; h++) begin
                cls_q[h]  <= CL_X;
                ycnt_q[h] <= '0;
            end
        end else begin
            for (int h = 0; h < 2; h++) begin
                cls_q[h] <= cls_now[h];
                if (cls_now[h] == CL_Y) begin
                    if (cls_q[h] != CL_Y)
                        ycnt_q[h] <= '0;
                    else if (tick_1hz && ycnt_q[h] != 4'hF)
                        ycnt_q[h] <= ycnt_q[h] + 4'd1;
                end
            end
        end
    end

    // Debounce only accumulates while running, so every ARM entry starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                db_cnt[i] <= (state == ST_RUN && cond[i]) ? db_cnt[i] + DW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ARM;
            arm_cnt      <= '0;
            system_fault <= 1'b0;
            armed        <= 1'b0;
            fault_code   <= 3'd0;
            fault_count  <= 8'd0;
        end else begin
            case (state)
                ST_ARM: begin
                    if (tick_1hz) begin
                        if (arm_cnt == ARM_LAST) begin
                            state <= ST_RUN;
                            armed <= 1'b1;
                        end else begin
                            arm_cnt <= arm_cnt + AW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (trip_code != 3'd0) begin
                        state        <= ST_TRIPPED;
                        armed        <= 1'b0;
                        system_fault <= 1'b1;
                        fault_code   <= trip_code;
                        if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
                    end
                end
                ST_TRIPPED: begin
                    if (fault_clear && cond == 3'b000) begin
                        state        <= ST_ARM;
                        arm_cnt      <= '0;
                        system_fault <= 1'b0;
                        fault_code   <= 3'd0;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    assign dbg_state = state;
endmodule
